// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit with HI/LO result registers.
// Optional macro MULDIV_EARLY_TERM_EN: multiply leaves RUN once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned W2    = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic               neg_res, neg_rem, dz_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   x;    // multiplier (shifts out) / dividend shifting into quotient
  logic [WIDTH-1:0]   y;    // multiplicand / divisor magnitude
  logic [W2-1:0]      acc;  // product; upper half doubles as divide remainder

  logic               accept_c, a_neg_c, b_neg_c, last_iter_c;
  logic [WIDTH-1:0]   a_abs_c, b_abs_c;
  logic [WIDTH:0]     sum_c, shifted_c, diff_c;
  logic [W2-1:0]      prod_c, prod_fix_c;
  logic [WIDTH-1:0]   quo_fix_c, rem_fix_c;

  // Operand capture and per-iteration datapath
  always_comb begin
    accept_c  = (state == S_IDLE) && start && !busy;
    a_neg_c   = !op[1] && a[WIDTH-1];
    b_neg_c   = !op[1] && b[WIDTH-1];
    a_abs_c   = a_neg_c ? -a : a;
    b_abs_c   = b_neg_c ? -b : b;
    sum_c     = {1'b0, acc[W2-1:WIDTH]} + (x[0] ? {1'b0, y} : '0);
    shifted_c = {acc[W2-1:WIDTH], x[WIDTH-1]};
    diff_c    = shifted_c - {1'b0, y};
`ifdef MULDIV_EARLY_TERM_EN
    last_iter_c = (cnt == CNT_W'(WIDTH - 1)) || (!op_q[0] && (x[WIDTH-1:1] == '0));
    prod_c      = acc >> (CNT_W'(WIDTH) - cnt);
`else
    last_iter_c = (cnt == CNT_W'(WIDTH - 1));
    prod_c      = acc;
`endif
    prod_fix_c = neg_res ? -prod_c : prod_c;
    quo_fix_c  = neg_res ? -x : x;
    rem_fix_c  = neg_rem ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept_c) state_nxt = (op[0] && (b == '0)) ? S_DONE : S_RUN;
      S_RUN:  if (last_iter_c) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Work registers and registered outputs (outputs trail the state by one cycle)
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz_q     <= 1'b0;
      cnt      <= '0;
      x        <= '0;
      y        <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      busy     <= (state != S_IDLE);
      done     <= (state == S_DONE);
      div_zero <= (state == S_DONE) && dz_q;
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            op_q    <= op;
            x       <= a_abs_c;
            y       <= b_abs_c;
            neg_res <= a_neg_c ^ b_neg_c;
            neg_rem <= a_neg_c;
            dz_q    <= op[0] && (b == '0);
            cnt     <= '0;
            acc     <= '0;
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (!op_q[0]) begin
            acc <= {sum_c, acc[WIDTH-1:1]};
            x   <= x >> 1;
          end else begin
            acc[W2-1:WIDTH] <= diff_c[WIDTH] ? shifted_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
            x               <= {x[WIDTH-2:0], ~diff_c[WIDTH]};
          end
        end
        S_FIX: begin
          if (!op_q[0]) begin
            hi <= prod_fix_c[W2-1:WIDTH];
            lo <= prod_fix_c[WIDTH-1:0];
          end else begin
            hi <= rem_fix_c;
            lo <= quo_fix_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
